// File: rtl/spi_button_decoder_if.sv
// Byte-level link between spi_dev_core and the button decoder, plus the
// decoded button outputs.
interface spi_button_decoder_if #(
    parameter int NBTN = 16
);
    // usr_mosi_stb qualifies usr_mosi_data for exactly one cycle; there is no
    // ready/backpressure, so the decoder must accept every strobe it sees.
    logic [7:0]      usr_mosi_data;
    logic            usr_mosi_stb;
    logic            csn_fall;
    logic            csn_rise;
    logic [NBTN-1:0] btn_state;
    logic [NBTN-1:0] btn_mask;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;
    logic            update_stb;
    logic            frame_err;

    modport slave (
        input  usr_mosi_data, usr_mosi_stb, csn_fall, csn_rise,
        output btn_state, btn_mask, btn_press, btn_release, update_stb, frame_err
    );

    modport master (
        output usr_mosi_data, usr_mosi_stb, csn_fall, csn_rise,
        input  btn_state, btn_mask, btn_press, btn_release, update_stb, frame_err
    );
endinterface

// File: rtl/spi_button_decoder.sv
// Decodes CMD-prefixed SPI button frames (mask bytes then state bytes) into a
// persistent button-state register with press/release/update/error pulses.
module spi_button_decoder #(
    parameter logic [7:0] CMD  = 8'hF4,
    parameter int         NBTN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_button_decoder_if.slave  bus,
    output logic [1:0]           o_dbg_state
);
    localparam int NBYTES = NBTN / 4;
    localparam int CW     = $clog2(NBYTES + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(NBYTES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NBYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMD     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_SKIP    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [2*NBTN-1:0] r_shift;
    logic [NBTN-1:0]   r_btn_state;
    logic [NBTN-1:0]   r_btn_mask;
    logic [NBTN-1:0]   r_btn_press;
    logic [NBTN-1:0]   r_btn_release;
    logic              r_update_stb;
    logic              r_frame_err;

    logic              w_commit;
    logic              w_err;
    logic              w_shift;
    logic [NBTN-1:0]   w_rx_mask;
    logic [NBTN-1:0]   w_rx_state;
    logic [NBTN-1:0]   w_new_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // csn_fall wins over csn_rise: the finishing frame is judged by the
    // output logic in the same cycle, and the new frame starts in CMD.
    always_comb begin
        w_next = r_state;
        if (bus.csn_fall) begin
            w_next = S_CMD;
        end else if (bus.csn_rise) begin
            w_next = S_IDLE;
        end else if (r_state == S_CMD && bus.usr_mosi_stb) begin
            w_next = (bus.usr_mosi_data == CMD) ? S_PAYLOAD : S_SKIP;
        end
    end

    always_comb begin
        w_commit = 1'b0;
        w_err    = 1'b0;
        w_shift  = 1'b0;
        if (r_state == S_PAYLOAD) begin
            w_commit = bus.csn_rise && (r_cnt == CNT_FULL);
            w_err    = bus.csn_rise && (r_cnt != CNT_FULL);
            w_shift  = bus.usr_mosi_stb && !bus.csn_fall && !bus.csn_rise;
        end
    end

    assign w_rx_mask   = r_shift[2*NBTN-1:NBTN];
    assign w_rx_state  = r_shift[NBTN-1:0];
    assign w_new_state = (r_btn_state & ~w_rx_mask) | (w_rx_state & w_rx_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_shift       <= '0;
            r_btn_state   <= '0;
            r_btn_mask    <= '0;
            r_btn_press   <= '0;
            r_btn_release <= '0;
            r_update_stb  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_btn_press   <= '0;
            r_btn_release <= '0;
            r_update_stb  <= 1'b0;
            r_frame_err   <= w_err;
            if (bus.csn_fall) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_shift) begin
                r_shift <= {r_shift[2*NBTN-9:0], bus.usr_mosi_data};
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_commit) begin
                r_btn_mask    <= w_rx_mask;
                r_btn_state   <= w_new_state;
                r_btn_press   <= w_new_state & ~r_btn_state;
                r_btn_release <= r_btn_state & ~w_new_state;
                r_update_stb  <= 1'b1;
            end
        end
    end

    assign bus.btn_state   = r_btn_state;
    assign bus.btn_mask    = r_btn_mask;
    assign bus.btn_press   = r_btn_press;
    assign bus.btn_release = r_btn_release;
    assign bus.update_stb  = r_update_stb;
    assign bus.frame_err   = r_frame_err;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_spi_button_decoder.sv
// Randomized bench for spi_button_decoder with a byte-array frame model.
module tb_spi_button_decoder;
    localparam logic [7:0] CMD    = 8'hF4;
    localparam int         NBTN   = 16;
    localparam int         NBYTES = NBTN / 4;
    localparam int         HALF   = NBTN / 8;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    spi_button_decoder_if #(.NBTN(NBTN)) bus ();

    spi_button_decoder #(.CMD(CMD), .NBTN(NBTN)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_cmp;
    int              n_mis;
    logic [7:0]      frame_q[$];
    logic [NBTN-1:0] exp_state;
    logic [NBTN-1:0] exp_mask;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All drivers start and end #1 after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        bus.usr_mosi_data = b;
        bus.usr_mosi_stb  = 1'b1;
        tick();
        bus.usr_mosi_stb  = 1'b0;
        bus.usr_mosi_data = 8'($urandom);
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
    endtask

    task automatic run_frame(input bit start_fall, input bit end_combined, input bit noise);
        logic [NBTN-1:0] m, s, new_st;
        logic [NBTN-1:0] e_press, e_rel;
        bit e_upd, e_err;
        if (start_fall) begin
            if (noise) send_byte(8'($urandom));
            bus.csn_fall = 1'b1;
            if (noise) begin
                bus.usr_mosi_stb  = 1'b1;
                bus.usr_mosi_data = CMD;
            end
            tick();
            bus.csn_fall     = 1'b0;
            bus.usr_mosi_stb = 1'b0;
        end
        foreach (frame_q[i]) send_byte(frame_q[i]);
        bus.csn_rise = 1'b1;
        bus.csn_fall = end_combined;
        if (noise) begin
            bus.usr_mosi_stb  = 1'b1;
            bus.usr_mosi_data = 8'($urandom);
        end
        tick();
        bus.csn_rise     = 1'b0;
        bus.csn_fall     = 1'b0;
        bus.usr_mosi_stb = 1'b0;

        e_upd = 1'b0; e_err = 1'b0; e_press = '0; e_rel = '0;
        if (frame_q.size() > 0 && frame_q[0] == CMD) begin
            if (frame_q.size() == 1 + NBYTES) begin
                m = '0; s = '0;
                for (int i = 0; i < HALF; i++) begin
                    m = (m << 8) | NBTN'(frame_q[1 + i]);
                    s = (s << 8) | NBTN'(frame_q[1 + HALF + i]);
                end
                new_st    = (exp_state & ~m) | (s & m);
                e_press   = new_st & ~exp_state;
                e_rel     = exp_state & ~new_st;
                exp_state = new_st;
                exp_mask  = m;
                e_upd     = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end
        chk("update_stb", bus.update_stb, e_upd);
        chk("frame_err", bus.frame_err, e_err);
        chk("btn_state", bus.btn_state, exp_state);
        chk("btn_mask", bus.btn_mask, exp_mask);
        chk("btn_press", bus.btn_press, e_press);
        chk("btn_release", bus.btn_release, e_rel);
        tick();
        chk("update_stb_clr", bus.update_stb, 1'b0);
        chk("frame_err_clr", bus.frame_err, 1'b0);
        chk("press_clr", bus.btn_press, '0);
        chk("release_clr", bus.btn_release, '0);
        chk("state_hold", bus.btn_state, exp_state);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, bus.btn_state, '0);
        chk({tag, "_mask"}, bus.btn_mask, '0);
        chk({tag, "_press"}, bus.btn_press, '0);
        chk({tag, "_release"}, bus.btn_release, '0);
        chk({tag, "_upd"}, bus.update_stb, 1'b0);
        chk({tag, "_err"}, bus.frame_err, 1'b0);
    endtask

    initial begin
        bit chained;
        bit comb;
        int kind;
        int len;
        n_cmp = 0;
        n_mis = 0;
        exp_state = '0;
        exp_mask  = '0;
        rst = 1'b1;
        bus.usr_mosi_data = 8'h00;
        bus.usr_mosi_stb  = 1'b0;
        bus.csn_fall      = 1'b0;
        bus.csn_rise      = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        frame_q = '{8'hF4, 8'h00, 8'h0F, 8'h00, 8'h05};
        run_frame(1, 0, 0);
        chk("t1_state_const", bus.btn_state, 16'h0005);
        chk("t1_mask_const", bus.btn_mask, 16'h000F);

        frame_q = '{8'hF4, 8'h00, 8'h03, 8'h00, 8'h02};
        run_frame(1, 0, 0);
        chk("t2_state_const", bus.btn_state, 16'h0006);

        frame_q = '{8'hF5, 8'h00, 8'hFF, 8'h00, 8'hFF};
        run_frame(1, 0, 0);
        frame_q = '{8'hF4, 8'h00, 8'h0F, 8'h00};
        run_frame(1, 0, 0);
        frame_q = '{8'hF4, 8'h00, 8'h0F, 8'h00, 8'h05, 8'hAA};
        run_frame(1, 0, 0);
        chk("t4_state_const", bus.btn_state, 16'h0006);

        // Reset in the middle of a frame, then a stray csn_rise.
        bus.csn_fall = 1'b1;
        tick();
        bus.csn_fall = 1'b0;
        send_byte(8'hF4);
        send_byte(8'h00);
        send_byte(8'h0F);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_state = '0;
        exp_mask  = '0;
        check_all_zero("mid_rst");
        bus.csn_rise = 1'b1;
        tick();
        bus.csn_rise = 1'b0;
        check_all_zero("stray_rise");
        tick();
        check_all_zero("stray_rise2");

        frame_q = '{8'hF4, 8'h00, 8'h0F, 8'h00, 8'h05};
        run_frame(1, 0, 0);
        frame_q = '{8'hF4, 8'h00, 8'h00, 8'hFF, 8'hFF};
        run_frame(1, 0, 0);
        frame_q = '{8'hF4, 8'hFF, 8'h00, 8'hA5, 8'h00};
        run_frame(1, 1, 0);
        frame_q = '{8'hF4, 8'h0F, 8'hF0, 8'h0C, 8'h30};
        run_frame(0, 0, 0);

        chained = 1'b0;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 5);
            frame_q = {};
            if (kind <= 2) begin
                frame_q.push_back(CMD);
                for (int i = 0; i < NBYTES; i++) frame_q.push_back(8'($urandom));
            end else if (kind == 3) begin
                len = $urandom_range(1, 6);
                frame_q.push_back(8'($urandom_range(0, 255)) ^ ((($urandom & 1) == 0) ? 8'h01 : 8'h80) ^ CMD);
                for (int i = 1; i < len; i++) frame_q.push_back(8'($urandom));
            end else if (kind == 4) begin
                len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, NBYTES) : $urandom_range(NBYTES + 2, NBYTES + 4);
                frame_q.push_back(CMD);
                for (int i = 1; i < len; i++) frame_q.push_back(8'($urandom));
            end
            comb = ($urandom_range(0, 3) == 0);
            run_frame(!chained, comb, ($urandom_range(0, 1) == 1));
            chained = comb;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/spi_button_decoder.md
Name: spi_button_decoder

Overview:
- Parametrised decoder for SPI button-report frames, driven by the byte-level interface of spi_dev_core (usr_mosi_data/usr_mosi_stb, csn_fall/csn_rise).
- Accepts frames of a configurable command byte followed by an NBTN-bit mask and an NBTN-bit state.
- Validates frame length and applies masked updates to a persistent button-state register.
- Emits per-button press/release pulses, an update strobe and a frame-error pulse for downstream LED, game or menu logic.

Parameters:
- CMD, 8'hF4, command byte that selects this decoder.
- NBTN, 16, number of buttons; must be a multiple of 8, range 8..64.
- Derived, not overridable: NBYTES = NBTN/4, the payload byte count (mask bytes followed by state bytes).

Ports:
- clk  in  1  system clock, 48 MHz domain of spi_dev_core.
- rst  in  1  reset, synchronous, active-high.
- usr_mosi_data  in  8  received byte.
- usr_mosi_stb  in  1  one-cycle strobe; usr_mosi_data valid.
- csn_fall  in  1  one-cycle pulse at frame start.
- csn_rise  in  1  one-cycle pulse at frame end.
- btn_state  out  NBTN  current button state; 1 = pressed.
- btn_mask  out  NBTN  mask of the last committed frame.
- btn_press  out  NBTN  one-cycle pulse per button on a 0->1 transition.
- btn_release  out  NBTN  one-cycle pulse per button on a 1->0 transition.
- update_stb  out  1  one-cycle pulse; a valid frame was committed.
- frame_err  out  1  one-cycle pulse; a CMD frame had the wrong length.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high. While rst=1, all outputs are 0, the FSM is in IDLE, and the shift register and counter are cleared.
- FSM states:
  - IDLE: waits for csn_fall; go to CMD.
  - CMD: on the first usr_mosi_stb, go to PAYLOAD if data==CMD, else go to SKIP.
  - PAYLOAD: on each strobe, shift the byte into a 2*NBTN-bit register (MSB-first) and increment the byte counter. The counter saturates at NBYTES+1.
  - SKIP: ignore bytes until csn_rise.
- csn_rise handling (all states return to IDLE):
  - PAYLOAD with count==NBYTES: commit.
  - PAYLOAD with count!=NBYTES (short or long): pulse frame_err, no commit.
  - CMD with zero bytes: no commit, no error.
  - SKIP: no commit, no error.
  - IDLE: no effect.
- Byte order: first payload byte = mask[NBTN-1:NBTN-8]; the last mask byte is followed by state[NBTN-1:NBTN-8]; the last byte = state[7:0].
- Commit at csn_rise in cycle N; all results visible in cycle N+1:
  - btn_mask <= rx_mask.
  - btn_state <= (btn_state & ~rx_mask) | (rx_state & rx_mask). Unmasked bits retain their value.
  - btn_press = new & ~old; btn_release = old & ~new. Both reduce to masked bits only.
  - update_stb = 1, even if no bit changed.
- Pulse outputs (btn_press, btn_release, update_stb, frame_err) are high for exactly one cycle and 0 otherwise.
- Boundary conditions:
  - csn_fall in any state: discard partial data, clear the counter, go to CMD.
  - csn_rise and csn_fall in the same cycle: evaluate the commit/error for the current frame first, then enter CMD.
  - usr_mosi_stb in the same cycle as csn_fall: the byte is dropped.
  - usr_mosi_stb in the same cycle as csn_rise: the byte is dropped; the decision uses the bytes already counted.
  - usr_mosi_stb in IDLE: ignored.
  - rst mid-frame: the frame is discarded. A subsequent csn_rise without csn_fall has no effect.
- Implementation limits: no combinational path from inputs to outputs; all outputs registered.

Test Plan (CMD=F4, NBTN=16, NBYTES=4):
1. Frame F4 00 0F 00 05:
   - Cycle after csn_rise: btn_state=0x0005, btn_mask=0x000F, btn_press=0x0005, btn_release=0x0000, update_stb=1 for one cycle.
   - Pulses return to 0 next cycle.
2. Following frame F4 00 03 00 02:
   - btn_state=0x0006, btn_press=0x0002, btn_release=0x0001.
   - Bit 2 is retained because it is unmasked.
3. Frame F5 00 FF 00 FF:
   - No update_stb, no frame_err, btn_state unchanged.
4. Length errors:
   - Frame F4 00 0F 00 (short): frame_err one cycle, no update_stb, state unchanged.
   - Frame F4 00 0F 00 05 AA (long): frame_err one cycle, state unchanged.
5. Reset mid-frame:
   - Send F4 00 0F, assert rst 2 cycles, then csn_rise: all outputs 0, no pulses.
   - A next valid frame commits normally.
6. Zero-mask frame and back-to-back frames:
   - Frame F4 00 00 FF FF: update_stb=1, btn_state unchanged, btn_press=btn_release=0.
   - Back-to-back frames with csn_rise and csn_fall in the same cycle: both commit correctly.
